// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts decoded instructions, reads up to two source
// registers from an 8x8 register file, forwards writebacks, tracks pending
// destination writes in a busy scoreboard and hands operands to execute.
module operand_fetch #(
    parameter  int DATA_WIDTH = 8,
    parameter  int ADDR_WIDTH = 3,
    parameter  int TAG_WIDTH  = 4,
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    // issue side
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] issue_rs0,
    input  logic                  issue_rs0_used,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic                  issue_rs1_used,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  issue_rd_used,
    input  logic [TAG_WIDTH-1:0]  issue_tag,
    // register file read ports
    output logic                  rd0_enable,
    output logic [ADDR_WIDTH-1:0] rd0_addr,
    input  logic [DATA_WIDTH-1:0] rd0_data,
    output logic                  rd1_enable,
    output logic [ADDR_WIDTH-1:0] rd1_addr,
    input  logic [DATA_WIDTH-1:0] rd1_data,
    // register file write port
    output logic                  wr_enable,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    // writeback from execute
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    // execute side
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic [ADDR_WIDTH-1:0] op_rd,
    output logic                  op_rd_used,
    output logic [TAG_WIDTH-1:0]  op_tag,
    output logic [NUM_REGS-1:0]   busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD
    } state_e;

    // Instruction fields captured at accept, plus writebacks seen on that edge
    // (the register file returns the pre-write value, so those must be kept).
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rs0;
        logic                  rs0_used;
        logic [ADDR_WIDTH-1:0] rs1;
        logic                  rs1_used;
        logic [ADDR_WIDTH-1:0] rd;
        logic                  rd_used;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  fwd0_hit;
        logic [DATA_WIDTH-1:0] fwd0_data;
        logic                  fwd1_hit;
        logic [DATA_WIDTH-1:0] fwd1_data;
    } instr_t;

    state_e                state_q, state_d;
    instr_t                instr_q, instr_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  op_valid_q, op_valid_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [ADDR_WIDTH-1:0] op_rd_q, op_rd_d;
    logic                  op_rd_used_q, op_rd_used_d;
    logic [TAG_WIDTH-1:0]  op_tag_q, op_tag_d;

    logic hz;
    logic accept;

    // Operand select: unused -> 0, live writeback, writeback latched at accept,
    // otherwise the register file read data.
    function automatic logic [DATA_WIDTH-1:0] pick_operand(
        input logic                  used,
        input logic                  live_hit,
        input logic                  fwd_hit,
        input logic [DATA_WIDTH-1:0] fwd_data,
        input logic [DATA_WIDTH-1:0] live_data,
        input logic [DATA_WIDTH-1:0] rf_data
    );
        if (!used)         return '0;
        else if (live_hit) return live_data;
        else if (fwd_hit)  return fwd_data;
        else               return rf_data;
    endfunction

    // Hazard: a pending write to any used register that is not being resolved
    // by a writeback this very cycle.
    always_comb begin
        hz = (issue_rs0_used && busy_q[issue_rs0] && !(wb_valid && wb_addr == issue_rs0))
          || (issue_rs1_used && busy_q[issue_rs1] && !(wb_valid && wb_addr == issue_rs1))
          || (issue_rd_used  && busy_q[issue_rd]  && !(wb_valid && wb_addr == issue_rd));
    end

    assign issue_ready = (state_q == IDLE) && !hz && !reset;
    assign accept      = issue_valid && issue_ready;

    // Read requests go out in the accept cycle, straight from the issue inputs.
    assign rd0_enable = accept && issue_rs0_used;
    assign rd0_addr   = issue_rs0;
    assign rd1_enable = accept && issue_rs1_used;
    assign rd1_addr   = issue_rs1;

    // Writeback stream passes straight through to the register file.
    assign wr_enable = wb_valid && !reset;
    assign wr_addr   = wb_addr;
    assign wr_data   = wb_data;

    assign op_valid   = op_valid_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_rd      = op_rd_q;
    assign op_rd_used = op_rd_used_q;
    assign op_tag     = op_tag_q;
    assign busy       = busy_q;

    // Next-state logic for the FSM, captured instruction and operand outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise paths
        // that skip an assignment would infer a latch.
        state_d      = state_q;
        instr_d      = instr_q;
        op_valid_d   = op_valid_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_rd_d      = op_rd_q;
        op_rd_used_d = op_rd_used_q;
        op_tag_d     = op_tag_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    instr_d.rs0       = issue_rs0;
                    instr_d.rs0_used  = issue_rs0_used;
                    instr_d.rs1       = issue_rs1;
                    instr_d.rs1_used  = issue_rs1_used;
                    instr_d.rd        = issue_rd;
                    instr_d.rd_used   = issue_rd_used;
                    instr_d.tag       = issue_tag;
                    instr_d.fwd0_hit  = wb_valid && (wb_addr == issue_rs0);
                    instr_d.fwd0_data = wb_data;
                    instr_d.fwd1_hit  = wb_valid && (wb_addr == issue_rs1);
                    instr_d.fwd1_data = wb_data;
                    state_d           = READ;
                end
            end
            READ: begin
                op_a_d = pick_operand(instr_q.rs0_used, wb_valid && (wb_addr == instr_q.rs0),
                                      instr_q.fwd0_hit, instr_q.fwd0_data, wb_data, rd0_data);
                op_b_d = pick_operand(instr_q.rs1_used, wb_valid && (wb_addr == instr_q.rs1),
                                      instr_q.fwd1_hit, instr_q.fwd1_data, wb_data, rd1_data);
                op_rd_d      = instr_q.rd;
                op_rd_used_d = instr_q.rd_used;
                op_tag_d     = instr_q.tag;
                op_valid_d   = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scoreboard: writebacks clear, accepts with a destination set; set wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) busy_d[wb_addr] = 1'b0;
        if (accept && issue_rd_used) busy_d[issue_rd] = 1'b1;
    end

    // State registers with synchronous reset; an in-flight op is dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            busy_q       <= '0;
            op_valid_q   <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_rd_q      <= '0;
            op_rd_used_q <= 1'b0;
            op_tag_q     <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            busy_q       <= busy_d;
            op_valid_q   <= op_valid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_rd_q      <= op_rd_d;
            op_rd_used_q <= op_rd_used_d;
            op_tag_q     <= op_tag_d;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch, with a behavioural 8x8 register file
// (registered read data, read-before-write on a shared edge).
module tb_operand_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid, issue_ready;
    logic [2:0] issue_rs0, issue_rs1, issue_rd;
    logic       issue_rs0_used, issue_rs1_used, issue_rd_used;
    logic [3:0] issue_tag;
    logic       rd0_enable, rd1_enable;
    logic [2:0] rd0_addr, rd1_addr;
    logic [7:0] rd0_data, rd1_data;
    logic       wr_enable;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       wb_valid;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       op_valid, op_ready;
    logic [7:0] op_a, op_b;
    logic [2:0] op_rd;
    logic       op_rd_used;
    logic [3:0] op_tag;
    logic [7:0] busy;

    int n_checks = 0;
    int n_fail   = 0;

    operand_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .TAG_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs0(issue_rs0), .issue_rs0_used(issue_rs0_used),
        .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
        .issue_rd(issue_rd), .issue_rd_used(issue_rd_used), .issue_tag(issue_tag),
        .rd0_enable(rd0_enable), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
        .rd1_enable(rd1_enable), .rd1_addr(rd1_addr), .rd1_data(rd1_data),
        .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_rd(op_rd), .op_rd_used(op_rd_used), .op_tag(op_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file model: read data registered, pre-write value on collision.
    logic [7:0] rf_mem [8];
    always @(posedge clk) begin
        if (rd0_enable) rd0_data <= rf_mem[rd0_addr];
        if (rd1_enable) rd1_data <= rf_mem[rd1_addr];
        if (wr_enable)  rf_mem[wr_addr] <= wr_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [2:0] rs0, input logic u0, input logic [2:0] rs1,
                             input logic u1, input logic [2:0] rd, input logic rdu,
                             input logic [3:0] tag);
        issue_valid = 1'b1;
        issue_rs0 = rs0; issue_rs0_used = u0;
        issue_rs1 = rs1; issue_rs1_used = u1;
        issue_rd  = rd;  issue_rd_used  = rdu;
        issue_tag = tag;
    endtask

    // Bounded wait for issue_ready; returns before the accepting edge.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (issue_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bit ok;
        reset = 1'b1;
        set_issue(3'd0, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 4'd0);
        wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 8'hff;
        step(); step(); #1;
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL reset_issue_ready: got %b want 0", issue_ready); end
        n_checks++; if (rd0_enable !== 1'b0) begin n_fail++; $display("FAIL reset_rd0_enable: got %b want 0", rd0_enable); end
        n_checks++; if (wr_enable !== 1'b0) begin n_fail++; $display("FAIL reset_wr_enable: got %b want 0", wr_enable); end
        n_checks++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
        n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL reset_busy: got %h want 00", busy); end
        n_checks++; if ({op_a, op_b, op_rd, op_rd_used, op_tag} !== '0) begin n_fail++; $display("FAIL reset_op_fields: got %h %h %h %b %h want zeros", op_a, op_b, op_rd, op_rd_used, op_tag); end
        reset = 1'b0;
        issue_valid = 1'b0;
        wb_valid = 1'b0;
        step();
        ok = 1'b1;
    endtask

    task automatic test_wb_fill();
        for (int i = 0; i < 8; i++) begin
            wb_valid = 1'b1; wb_addr = 3'(i); wb_data = 8'(42 + i);
            #1;
            n_checks++;
            if ({wr_enable, wr_addr, wr_data} !== {1'b1, 3'(i), 8'(42 + i)}) begin
                n_fail++; $display("FAIL wb_passthru[%0d]: got %b/%0d/%0d want 1/%0d/%0d", i, wr_enable, wr_addr, wr_data, i, 42 + i);
            end
            step();
        end
        wb_valid = 1'b0;
    endtask

    task automatic test_read_ports();
        bit ok;
        op_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_issue(3'(i), 1'b1, 3'(7 - i), 1'b1, 3'd0, 1'b0, 4'(i));
            wait_ready(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL read_ready_timeout[%0d]: issue_ready never 1", i); end
            n_checks++; if ({rd0_enable, rd0_addr, rd1_enable, rd1_addr} !== {1'b1, 3'(i), 1'b1, 3'(7 - i)}) begin
                n_fail++; $display("FAIL read_req[%0d]: got %b/%0d %b/%0d want 1/%0d 1/%0d", i, rd0_enable, rd0_addr, rd1_enable, rd1_addr, i, 7 - i);
            end
            step();
            issue_valid = 1'b0;
            #1;
            n_checks++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL read_latency_early[%0d]: op_valid got %b want 0", i, op_valid); end
            step();
            n_checks++; if ({op_valid, op_a, op_b, op_tag} !== {1'b1, 8'(42 + i), 8'(49 - i), 4'(i)}) begin
                n_fail++; $display("FAIL read_op[%0d]: got v=%b a=%0d b=%0d tag=%0d want v=1 a=%0d b=%0d tag=%0d", i, op_valid, op_a, op_b, op_tag, 42 + i, 49 - i, i);
            end
            n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL read_busy[%0d]: got %h want 00", i, busy); end
            step();
            n_checks++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL read_drop[%0d]: op_valid got %b want 0", i, op_valid); end
        end
        op_ready = 1'b0;
    endtask

    task automatic test_hazard();
        bit ok;
        set_issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 4'd1);
        wait_ready(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL haz_rd_timeout: issue_ready never 1"); end
        step();
        issue_valid = 1'b0;
        #1;
        n_checks++; if (busy !== 8'h08) begin n_fail++; $display("FAIL haz_busy_set: got %h want 08", busy); end
        step();
        n_checks++; if ({op_valid, op_rd, op_rd_used} !== {1'b1, 3'd3, 1'b1}) begin n_fail++; $display("FAIL haz_op_rd: got v=%b rd=%0d used=%b want 1 3 1", op_valid, op_rd, op_rd_used); end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        set_issue(3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 4'd2);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL haz_stall[%0d]: issue_ready got %b want 0", c, issue_ready); end
            step();
        end
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 8'd99;
        #1;
        n_checks++; if ({issue_ready, rd0_enable} !== 2'b11) begin n_fail++; $display("FAIL haz_release: got ready=%b rd0=%b want 1 1", issue_ready, rd0_enable); end
        step();
        wb_valid = 1'b0; issue_valid = 1'b0;
        #1;
        n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL haz_busy_clear: got %h want 00", busy); end
        step();
        n_checks++; if ({op_valid, op_a} !== {1'b1, 8'd99}) begin n_fail++; $display("FAIL haz_fwd_op_a: got v=%b a=%0d want 1 99", op_valid, op_a); end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    task automatic test_forward();
        bit ok;
        set_issue(3'd5, 1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 4'd3);
        wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 8'd77;
        wait_ready(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fwd_timeout: issue_ready never 1"); end
        step();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 8'h5a;
        step();
        wb_valid = 1'b0;
        #1;
        n_checks++; if (op_a !== 8'd77) begin n_fail++; $display("FAIL fwd_accept_op_a: got %0d want 77", op_a); end
        n_checks++; if (op_b !== 8'h5a) begin n_fail++; $display("FAIL fwd_read_op_b: got %h want 5a", op_b); end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    task automatic test_set_wins();
        bit ok;
        set_issue(3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 4'd4);
        wb_valid = 1'b1; wb_addr = 3'd7; wb_data = 8'h11;
        wait_ready(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL setwin_timeout: issue_ready never 1"); end
        step();
        issue_valid = 1'b0; wb_valid = 1'b0;
        #1;
        n_checks++; if (busy !== 8'h80) begin n_fail++; $display("FAIL setwin_busy: got %h want 80", busy); end
        op_ready = 1'b1;
        step(); step();
        op_ready = 1'b0;
        wb_valid = 1'b1; wb_addr = 3'd7; wb_data = 8'h22;
        step();
        wb_valid = 1'b0;
        #1;
        n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL setwin_clear: got %h want 00", busy); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        op_ready = 1'b0;
        set_issue(3'd1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 4'd9);
        wait_ready(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_timeout: issue_ready never 1"); end
        step();
        set_issue(3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 4'd10);
        step();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if ({op_valid, op_a, op_b, op_tag, issue_ready} !== {1'b1, 8'd43, 8'd44, 4'd9, 1'b0}) begin
                n_fail++; $display("FAIL hold_stable[%0d]: got v=%b a=%0d b=%0d tag=%0d ready=%b want 1 43 44 9 0", c, op_valid, op_a, op_b, op_tag, issue_ready);
            end
            step();
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        #1;
        n_checks++; if ({op_valid, issue_ready} !== 2'b01) begin n_fail++; $display("FAIL hold_release: got v=%b ready=%b want 0 1", op_valid, issue_ready); end
        step();
        issue_valid = 1'b0;
        step();
        n_checks++; if ({op_valid, op_a, op_b, op_tag} !== {1'b1, 8'd42, 8'd0, 4'd10}) begin
            n_fail++; $display("FAIL b2b_op: got v=%b a=%0d b=%0d tag=%0d want 1 42 0 10", op_valid, op_a, op_b, op_tag);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    task automatic test_unused_src();
        bit ok;
        set_issue(3'd6, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 4'd5);
        wait_ready(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL unused_timeout: issue_ready never 1"); end
        n_checks++; if ({rd0_enable, rd1_enable, rd1_addr} !== {1'b0, 1'b1, 3'd2}) begin
            n_fail++; $display("FAIL unused_req: got rd0=%b rd1=%b addr=%0d want 0 1 2", rd0_enable, rd1_enable, rd1_addr);
        end
        step();
        issue_valid = 1'b0;
        step();
        n_checks++; if ({op_valid, op_a, op_b} !== {1'b1, 8'd0, 8'd44}) begin
            n_fail++; $display("FAIL unused_op: got v=%b a=%0d b=%0d want 1 0 44", op_valid, op_a, op_b);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        bit ok;
        set_issue(3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 4'd6);
        wait_ready(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rsth_timeout: issue_ready never 1"); end
        step();
        issue_valid = 1'b0;
        step();
        n_checks++; if ({op_valid, busy} !== {1'b1, 8'h10}) begin n_fail++; $display("FAIL rsth_pre: got v=%b busy=%h want 1 10", op_valid, busy); end
        reset = 1'b1;
        wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 8'hee;
        #1;
        n_checks++; if ({wr_enable, issue_ready} !== 2'b00) begin n_fail++; $display("FAIL rsth_wr_enable: got wr=%b ready=%b want 0 0", wr_enable, issue_ready); end
        step();
        reset = 1'b0;
        wb_valid = 1'b0;
        #1;
        n_checks++; if ({op_valid, busy, op_a} !== {1'b0, 8'h00, 8'd0}) begin n_fail++; $display("FAIL rsth_post: got v=%b busy=%h a=%0d want 0 00 0", op_valid, busy, op_a); end
        set_issue(3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 4'd7);
        #1;
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rsth_idle: issue_ready got %b want 1", issue_ready); end
        step();
        issue_valid = 1'b0;
        step();
        n_checks++; if ({op_valid, op_a} !== {1'b1, 8'd43}) begin n_fail++; $display("FAIL rsth_no_write: got v=%b a=%0d want 1 43", op_valid, op_a); end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        issue_valid = 1'b0;
        issue_rs0 = '0; issue_rs0_used = 1'b0;
        issue_rs1 = '0; issue_rs1_used = 1'b0;
        issue_rd = '0; issue_rd_used = 1'b0; issue_tag = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        op_ready = 1'b0;
        step();
        test_reset();
        test_wb_fill();
        test_read_ports();
        test_hazard();
        test_forward();
        test_set_wins();
        test_back_to_back();
        test_unused_src();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
